local_mem_avs_responder: RTL and testbench

Avalon-MM burst responder that models the board's local memory bank behind the AFU's local-memory master port. It accepts burst writes with byte masks and burst reads, and returns read data in order with a fixed latency. It is used as the local memory in simulation and on-chip scratch builds, and drives the other end of the same address, data and burst-count geometry the AFU's local-memory initiators use.

---
 rtl/local_mem_avs_responder_if.sv | 29 ++
 rtl/local_mem_avs_responder.sv | 164 ++++++++++++++++
 tb/tb_local_mem_avs_responder.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/local_mem_avs_responder_if.sv
// Avalon-MM burst bus between a local-memory initiator and its memory bank.
// The master modport drives commands and the slave modport returns read data.
interface local_mem_avs_responder_if #(
    parameter int ADDR_WIDTH      = 26,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7
);
    logic [ADDR_WIDTH-1:0]      avs_address;
    logic                       avs_read;
    logic                       avs_write;
    logic [BURST_CNT_WIDTH-1:0] avs_burstcount;
    logic [DATA_WIDTH-1:0]      avs_writedata;
    logic [DATA_WIDTH/8-1:0]    avs_byteenable;
    logic                       avs_waitrequest;
    logic [DATA_WIDTH-1:0]      avs_readdata;
    logic                       avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_burstcount,
        output avs_writedata, avs_byteenable,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_burstcount,
        input  avs_writedata, avs_byteenable,
        output avs_waitrequest, avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/local_mem_avs_responder.sv
// Avalon-MM burst responder modelling the local memory bank.
// Optional LOCAL_MEM_RESP_STALL_EN adds LFSR-driven waitrequest stalls.
module local_mem_avs_responder #(
    parameter int ADDR_WIDTH      = 26,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int MEM_DEPTH_LOG2  = 10,
    parameter int READ_LATENCY    = 2
) (
    input logic                      clk,
    input logic                      reset,
    local_mem_avs_responder_if.slave avs
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH    = 1 << MEM_DEPTH_LOG2;

    typedef logic [MEM_DEPTH_LOG2-1:0]  line_t;
    typedef logic [BURST_CNT_WIDTH-1:0] cnt_t;
    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    state_t state;
    line_t  ptr;
    cnt_t   wr_left;
    cnt_t   iss_left;
    cnt_t   ret_left;
    logic   wait_q;
    logic   stall;
    logic   accept;
    logic   wr_fire;
    logic   rd_fire;
    logic   issue;
    line_t  cmd_line;
    line_t  wr_line;
    cnt_t   burst_len;
    logic   unused_addr_bits;

    logic [DATA_WIDTH-1:0]   mem    [DEPTH];
    logic [READ_LATENCY-1:0] pipe_v;
    logic [DATA_WIDTH-1:0]   pipe_d [READ_LATENCY];

    // Upper address bits alias onto the backing store.
    assign cmd_line = avs.avs_address[MEM_DEPTH_LOG2-1:0];
    assign unused_addr_bits = ^avs.avs_address[ADDR_WIDTH-1:MEM_DEPTH_LOG2];

    // A zero burst count is treated as a single beat.
    assign burst_len = (avs.avs_burstcount == '0) ? cnt_t'(1)
                                                  : avs.avs_burstcount;

    assign accept  = !avs.avs_waitrequest && !reset;
    assign wr_fire = accept && avs.avs_write && (state != RD_BURST);
    // Write wins a simultaneous read/write; the read is dropped.
    assign rd_fire = accept && avs.avs_read && !avs.avs_write
                     && (state == IDLE);
    assign wr_line = (state == IDLE) ? cmd_line : ptr;
    assign issue   = (state == RD_BURST) && (iss_left != '0);

    assign avs.avs_waitrequest   = wait_q | stall;
    assign avs.avs_readdatavalid = pipe_v[READ_LATENCY-1];
    assign avs.avs_readdata      = pipe_d[READ_LATENCY-1];

`ifdef LOCAL_MEM_RESP_STALL_EN
    logic [15:0] lfsr;

    // Free-running LFSR that injects backpressure on the command side.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0],
                     lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = (state != RD_BURST) && (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Byte-masked write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (avs.avs_byteenable[i]) begin
                    mem[wr_line][i*8 +: 8] <= avs.avs_writedata[i*8 +: 8];
                end
            end
        end
    end

    // Read return pipeline; the last stage holds data between beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_v <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= issue;
            if (issue) begin
                pipe_d[0] <= mem[ptr];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                if (pipe_v[i-1]) begin
                    pipe_d[i] <= pipe_d[i-1];
                end
            end
        end
    end

    // Burst sequencer: tracks line pointer and beats left per direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_q   <= 1'b1;
            ptr      <= '0;
            wr_left  <= '0;
            iss_left <= '0;
            ret_left <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    wait_q <= 1'b0;
                    if (wr_fire) begin
                        ptr     <= cmd_line + 1'b1;
                        wr_left <= burst_len - 1'b1;
                        if (burst_len != cnt_t'(1)) begin
                            state <= WR_BURST;
                        end
                    end else if (rd_fire) begin
                        ptr      <= cmd_line;
                        iss_left <= burst_len;
                        ret_left <= burst_len;
                        wait_q   <= 1'b1;
                        state    <= RD_BURST;
                    end
                end
                WR_BURST: begin
                    if (wr_fire) begin
                        ptr     <= ptr + 1'b1;
                        wr_left <= wr_left - 1'b1;
                        if (wr_left == cnt_t'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                RD_BURST: begin
                    if (issue) begin
                        ptr      <= ptr + 1'b1;
                        iss_left <= iss_left - 1'b1;
                    end
                    if (avs.avs_readdatavalid) begin
                        ret_left <= ret_left - 1'b1;
                        if (ret_left == cnt_t'(1)) begin
                            state  <= IDLE;
                            wait_q <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_local_mem_avs_responder.sv
// Randomized bench for local_mem_avs_responder against a line-array model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_local_mem_avs_responder;
    localparam int AW    = 26;
    localparam int DW    = 512;
    localparam int BW    = 7;
    localparam int DL    = 10;
    localparam int L     = 2;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << DL;
    localparam int TMO   = 64;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    local_mem_avs_responder_if #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW)
    ) avs ();

    local_mem_avs_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW),
        .MEM_DEPTH_LOG2(DL), .READ_LATENCY(L)
    ) dut (
        .clk(clk),
        .reset(reset),
        .avs(avs)
    );

    int vectors = 0;
    int miscompares = 0;
    int stalls = 0;
    int wr_seen = 0;
    int rd_seen = 0;

    logic [DW-1:0] model [DEPTH];
    logic [NB-1:0] known [DEPTH];
    logic [DW-1:0] wbuf  [128];
    logic [NB-1:0] bebuf [128];

    function automatic logic [DW-1:0] expand(input logic [NB-1:0] be);
        logic [DW-1:0] r;
        for (int i = 0; i < NB; i++) r[i*8 +: 8] = {8{be[i]}};
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic wr_burst(input int addr, input int bc, input int bub);
        int n;
        int t;
        int line;
        n = (bc == 0) ? 1 : bc;
        for (int b = 0; b < n; b++) begin
            avs.avs_write      = 1'b1;
            avs.avs_address    = (b == 0) ? AW'(addr) : AW'($urandom);
            avs.avs_burstcount = (b == 0) ? BW'(bc) : BW'($urandom);
            avs.avs_writedata  = wbuf[b];
            avs.avs_byteenable = bebuf[b];
            t = 0;
            while (avs.avs_waitrequest === 1'b1 && t < TMO) begin
                stalls++;
                @(negedge clk);
                t++;
            end
            if (t >= TMO) begin
                vectors++;
                miscompares++;
                $display("FAIL wr_accept_timeout addr=%0d beat=%0d", addr, b);
                avs.avs_write = 1'b0;
                return;
            end
            @(posedge clk);
            wr_seen++;
            line = (addr + b) % DEPTH;
            for (int i = 0; i < NB; i++) begin
                if (bebuf[b][i]) begin
                    model[line][i*8 +: 8] = wbuf[b][i*8 +: 8];
                    known[line][i] = 1'b1;
                end
            end
            @(negedge clk);
            if (b == bub && b < n - 1) begin
                avs.avs_write = 1'b0;
                avs.avs_read  = 1'b1;
                @(negedge clk);
                avs.avs_read  = 1'b0;
            end
        end
        avs.avs_write = 1'b0;
    endtask

    task automatic rd_burst(input int addr, input int bc);
        int n;
        int t;
        int line;
        logic [DW-1:0] exp_d;
        logic [DW-1:0] msk;
        n = (bc == 0) ? 1 : bc;
        avs.avs_read       = 1'b1;
        avs.avs_address    = AW'(addr);
        avs.avs_burstcount = BW'(bc);
        t = 0;
        while (avs.avs_waitrequest === 1'b1 && t < TMO) begin
            stalls++;
            @(negedge clk);
            t++;
        end
        vectors++;
        if (t >= TMO) begin
            miscompares++;
            $display("FAIL rd_accept_timeout addr=%0d", addr);
            avs.avs_read = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        avs.avs_read       = 1'b0;
        avs.avs_address    = AW'($urandom);
        avs.avs_burstcount = BW'($urandom);
        for (int c = 0; c < L + n; c++) begin
            vectors++;
            if (avs.avs_waitrequest !== 1'b1) begin
                miscompares++;
                $display("FAIL rd_wait addr=%0d c=%0d got=%b want=1",
                         addr, c, avs.avs_waitrequest);
            end
            vectors++;
            if (avs.avs_readdatavalid !== (c >= L)) begin
                miscompares++;
                $display("FAIL rd_valid addr=%0d c=%0d got=%b want=%b",
                         addr, c, avs.avs_readdatavalid, (c >= L));
            end
            if (c >= L && avs.avs_readdatavalid === 1'b1) begin
                rd_seen++;
                line  = (addr + c - L) % DEPTH;
                exp_d = model[line];
                msk   = expand(known[line]);
                vectors++;
                if (((avs.avs_readdata ^ exp_d) & msk) !== '0) begin
                    miscompares++;
                    $display("FAIL rd_data line=%0d got=%h want=%h",
                             line, avs.avs_readdata, exp_d & msk);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (avs.avs_readdatavalid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_extra_valid addr=%0d got=%b want=0",
                     addr, avs.avs_readdatavalid);
        end
`ifndef LOCAL_MEM_RESP_STALL_EN
        vectors++;
        if (avs.avs_waitrequest !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_release addr=%0d got=%b want=0",
                     addr, avs.avs_waitrequest);
        end
`endif
    endtask

    task automatic test_reset();
        for (int i = 0; i < DEPTH; i++) known[i] = '0;
        reset = 1'b1;
        avs.avs_read = 1'b0;
        avs.avs_write = 1'b0;
        avs.avs_address = '0;
        avs.avs_burstcount = '0;
        avs.avs_writedata = '0;
        avs.avs_byteenable = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (avs.avs_waitrequest !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_wait got=%b want=1", avs.avs_waitrequest);
        end
        vectors++;
        if (avs.avs_readdatavalid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid got=%b want=0",
                     avs.avs_readdatavalid);
        end
        vectors++;
        if (avs.avs_readdata !== '0) begin
            miscompares++;
            $display("FAIL reset_data got=%h want=0", avs.avs_readdata);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (avs.avs_waitrequest !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release got=%b want=0",
                     avs.avs_waitrequest);
        end
    endtask

    task automatic test_single();
        wbuf[0]  = {NB{8'hA5}};
        bebuf[0] = '1;
        wr_burst(5, 1, -1);
        rd_burst(5, 1);
    endtask

    task automatic test_burst_bubble();
        for (int i = 0; i < 4; i++) begin
            wbuf[i]  = DW'(i + 1);
            bebuf[i] = '1;
        end
        wr_burst(8, 4, 1);
        rd_burst(8, 4);
    endtask

    task automatic test_byte_mask();
        wbuf[0]  = '1;
        bebuf[0] = '1;
        wr_burst(0, 1, -1);
        wbuf[0]  = '0;
        bebuf[0] = NB'(1);
        wr_burst(0, 1, -1);
        rd_burst(0, 1);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) begin
            wbuf[i]  = DW'(i + 7);
            bebuf[i] = '1;
        end
        wr_burst(1023, 3, -1);
        rd_burst(1023, 1);
        rd_burst(0, 1);
        rd_burst(1, 1);
        rd_burst(1024, 1);
        rd_burst(1023, 3);
    endtask

    task automatic test_burstcount_zero();
        wbuf[0]  = rand_line();
        bebuf[0] = '1;
        wr_burst(100, 0, -1);
        rd_burst(100, 0);
    endtask

    task automatic test_rw_collision();
        int t;
        wbuf[0] = rand_line();
        avs.avs_read       = 1'b1;
        avs.avs_write      = 1'b1;
        avs.avs_address    = AW'(20);
        avs.avs_burstcount = BW'(1);
        avs.avs_writedata  = wbuf[0];
        avs.avs_byteenable = '1;
        t = 0;
        while (avs.avs_waitrequest === 1'b1 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        model[20] = wbuf[0];
        known[20] = '1;
        @(negedge clk);
        avs.avs_read  = 1'b0;
        avs.avs_write = 1'b0;
        for (int c = 0; c < L + 3; c++) begin
            vectors++;
            if (avs.avs_readdatavalid !== 1'b0) begin
                miscompares++;
                $display("FAIL rw_dropped_read c=%0d got=%b want=0",
                         c, avs.avs_readdatavalid);
            end
            @(negedge clk);
        end
        rd_burst(20, 1);
    endtask

    task automatic test_reset_mid_read();
        int t;
        for (int i = 0; i < 8; i++) begin
            wbuf[i]  = rand_line();
            bebuf[i] = '1;
        end
        wr_burst(40, 8, -1);
        avs.avs_read       = 1'b1;
        avs.avs_address    = AW'(40);
        avs.avs_burstcount = BW'(8);
        t = 0;
        while (avs.avs_waitrequest === 1'b1 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        @(negedge clk);
        avs.avs_read = 1'b0;
        for (int c = 0; c <= L + 1; c++) begin
            if (c >= L) begin
                vectors++;
                if (avs.avs_readdatavalid !== 1'b1 ||
                    avs.avs_readdata !== model[40 + c - L]) begin
                    miscompares++;
                    $display("FAIL mid_pre_beat c=%0d v=%b got=%h", c,
                             avs.avs_readdatavalid, avs.avs_readdata);
                end
            end
            if (c < L + 1) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (avs.avs_readdatavalid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_valid got=%b want=0",
                     avs.avs_readdatavalid);
        end
        reset = 1'b0;
        @(negedge clk);
`ifndef LOCAL_MEM_RESP_STALL_EN
        vectors++;
        if (avs.avs_waitrequest !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_release_wait got=%b want=0",
                     avs.avs_waitrequest);
        end
`endif
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if (avs.avs_readdatavalid !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_post_valid c=%0d got=%b want=0",
                         c, avs.avs_readdatavalid);
            end
            @(negedge clk);
        end
        rd_burst(40, 8);
    endtask

    task automatic test_random();
        int wr_exp;
        int rd_exp;
        int n;
        int bc;
        int addr;
        int bub;
        wr_exp  = 0;
        rd_exp  = 0;
        wr_seen = 0;
        rd_seen = 0;
        stalls  = 0;
        for (int k = 0; k < 1000; k++) begin
            bc   = $urandom_range(0, 16);
            n    = (bc == 0) ? 1 : bc;
            addr = $urandom_range(0, 2 * DEPTH - 1);
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < n; i++) begin
                    wbuf[i]  = rand_line();
                    bebuf[i] = ($urandom_range(0, 3) == 0)
                               ? NB'({$urandom, $urandom}) : '1;
                end
                bub = $urandom_range(0, 3) == 0 ? $urandom_range(0, n) : -1;
                wr_exp += n;
                wr_burst(addr, bc, bub);
            end else begin
                rd_exp += n;
                rd_burst(addr, bc);
            end
        end
        vectors++;
        if (wr_seen !== wr_exp) begin
            miscompares++;
            $display("FAIL rand_wr_beats got=%0d want=%0d", wr_seen, wr_exp);
        end
        vectors++;
        if (rd_seen !== rd_exp) begin
            miscompares++;
            $display("FAIL rand_rd_beats got=%0d want=%0d", rd_seen, rd_exp);
        end
        vectors++;
`ifdef LOCAL_MEM_RESP_STALL_EN
        if (stalls == 0) begin
            miscompares++;
            $display("FAIL rand_stalls got=%0d want>0", stalls);
        end
`else
        if (stalls != 0) begin
            miscompares++;
            $display("FAIL rand_stalls got=%0d want=0", stalls);
        end
`endif
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog expired");
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_burst_bubble();
        test_byte_mask();
        test_wrap();
        test_burstcount_zero();
        test_rw_collision();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
